// File: rtl/connect_count_accumulator_if.sv
// rtl/connect_count_accumulator_if.sv - result stream and collector handshake bundle for the accumulator
interface connect_count_accumulator_if #(
  parameter int EXTRA_DATA_WIDTH = 14,
  parameter int SUM_WIDTH        = 48,
  parameter int COUNT_WIDTH      = 32
);
  logic                        startTop;
  logic [COUNT_WIDTH-1:0]      expectedCount;
  logic                        done;
  logic [5:0]                  resultCount;
  logic [EXTRA_DATA_WIDTH-1:0] extraDataIn;
  logic                        resultValid;
  logic                        resultAck;
  logic [SUM_WIDTH-1:0]        sumOut;
  logic [COUNT_WIDTH-1:0]      countOut;
  logic [EXTRA_DATA_WIDTH-1:0] checksumOut;
  logic                        overflow;
  logic                        busy;
  logic                        strayError;

  // Driver side: compute stage plus collector
  modport master (
    output startTop, expectedCount, done, resultCount, extraDataIn, resultAck,
    input  resultValid, sumOut, countOut, checksumOut, overflow, busy, strayError
  );

  // Accumulator side
  modport slave (
    input  startTop, expectedCount, done, resultCount, extraDataIn, resultAck,
    output resultValid, sumOut, countOut, checksumOut, overflow, busy, strayError
  );
endinterface

// File: rtl/connect_count_accumulator.sv
// rtl/connect_count_accumulator.sv - per-top sum of 2^resultCount with bot-index XOR checksum
module connect_count_accumulator #(
  parameter int EXTRA_DATA_WIDTH = 14,
  parameter int SUM_WIDTH        = 48,
  parameter int COUNT_WIDTH      = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  connect_count_accumulator_if.slave      bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCUM  = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_RESULT = 2'd3;

  localparam logic [SUM_WIDTH-1:0] ONE = {{(SUM_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]                  state_q, state_d;
  logic [COUNT_WIDTH-1:0]      expected_q, expected_d;
  logic [COUNT_WIDTH-1:0]      received_q, received_d;
  logic [EXTRA_DATA_WIDTH-1:0] checksum_q, checksum_d;
  logic [SUM_WIDTH-1:0]        v_q, v_d;
  logic [SUM_WIDTH-1:0]        sum_q, sum_d;
  logic                        overflow_q, overflow_d;
  logic                        result_valid_q, result_valid_d;
  logic                        busy_q, busy_d;
  logic                        stray_error_q, stray_error_d;
  logic [SUM_WIDTH:0]          sum_ext;

  // Next-state: stage-0 capture of 2^rc, stage-1 add with carry detection, top sequencing
  always_comb begin
    state_d       = state_q;
    expected_d    = expected_q;
    received_d    = received_q;
    checksum_d    = checksum_q;
    overflow_d    = overflow_q;
    v_d           = '0;
    stray_error_d = bus.done && (state_q != ST_ACCUM);

    // Stage 1 always folds in whatever stage 0 captured last cycle (zero when idle)
    sum_ext = {1'b0, sum_q} + {1'b0, v_q};
    sum_d   = sum_ext[SUM_WIDTH-1:0];
    if (sum_ext[SUM_WIDTH]) begin
      overflow_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.startTop) begin
          expected_d = bus.expectedCount;
          received_d = '0;
          checksum_d = '0;
          sum_d      = '0;
          overflow_d = 1'b0;
          state_d    = (bus.expectedCount == '0) ? ST_DRAIN : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (bus.done) begin
          received_d = received_q + COUNT_WIDTH'(1);
          checksum_d = checksum_q ^ bus.extraDataIn;
          // Exponents past the accumulator cannot be represented; flag instead of adding
          if (32'(bus.resultCount) >= 32'(SUM_WIDTH)) begin
            overflow_d = 1'b1;
          end else begin
            v_d = ONE << bus.resultCount;
          end
          if (received_d == expected_q) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        state_d = ST_RESULT;
      end
      default: begin
        if (bus.resultAck) begin
          state_d = ST_IDLE;
        end
      end
    endcase

    result_valid_d = (state_d == ST_RESULT);
    busy_d         = (state_d != ST_IDLE);
  end

  // State and datapath registers; reset discards any partial top
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      expected_q     <= '0;
      received_q     <= '0;
      checksum_q     <= '0;
      v_q            <= '0;
      sum_q          <= '0;
      overflow_q     <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      stray_error_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      expected_q     <= expected_d;
      received_q     <= received_d;
      checksum_q     <= checksum_d;
      v_q            <= v_d;
      sum_q          <= sum_d;
      overflow_q     <= overflow_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
      stray_error_q  <= stray_error_d;
    end
  end

  assign bus.resultValid = result_valid_q;
  assign bus.sumOut      = sum_q;
  assign bus.countOut    = received_q;
  assign bus.checksumOut = checksum_q;
  assign bus.overflow    = overflow_q;
  assign bus.busy        = busy_q;
  assign bus.strayError  = stray_error_q;

endmodule

// File: tb/tb_connect_count_accumulator.sv
// tb/tb_connect_count_accumulator.sv - directed and random checks against a behavioural model
module tb_connect_count_accumulator;
  localparam int EW = 14;
  localparam int SW = 48;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  connect_count_accumulator_if #(.EXTRA_DATA_WIDTH(EW), .SUM_WIDTH(SW), .COUNT_WIDTH(CW)) bus ();

  connect_count_accumulator #(.EXTRA_DATA_WIDTH(EW), .SUM_WIDTH(SW), .COUNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: a top collects a list of results; its total is the plain
  // arithmetic sum of powers of two, appearing two cycles after the last result.
  bit          m_busy, m_accepting, m_valid, m_stray, m_flush, m_big;
  int unsigned m_remaining, m_count, m_tops;
  logic [63:0] m_sum;
  logic [EW-1:0] m_chk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_accepting = 0; m_valid = 0; m_stray = 0; m_flush = 0; m_big = 0;
      m_remaining = 0; m_count = 0; m_sum = '0; m_chk = '0;
    end else begin
      m_stray = bus.done && !m_accepting;
      if (m_flush) begin
        m_valid = 1; m_flush = 0; m_tops++;
      end else if (m_valid && bus.resultAck) begin
        m_valid = 0; m_busy = 0;
      end else if (!m_busy && bus.startTop) begin
        m_busy = 1; m_sum = '0; m_count = 0; m_chk = '0; m_big = 0;
        m_remaining = bus.expectedCount;
        if (bus.expectedCount == 0) m_flush = 1;
        else m_accepting = 1;
      end else if (bus.done && m_accepting) begin
        m_count++;
        m_chk = m_chk ^ bus.extraDataIn;
        if (int'(bus.resultCount) >= SW) m_big = 1;
        else m_sum = m_sum + (64'd1 << bus.resultCount);
        m_remaining--;
        if (m_remaining == 0) begin
          m_accepting = 0; m_flush = 1;
        end
      end
    end
  end

  // Compare every cycle on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      chk("valid", bus.resultValid, m_valid);
      chk("busy", bus.busy, m_busy);
      chk("stray", bus.strayError, m_stray);
      if (m_valid) begin
        chk("sum", bus.sumOut, m_sum[SW-1:0]);
        chk("count", bus.countOut, m_count);
        chk("checksum", bus.checksumOut, m_chk);
        chk("overflow", bus.overflow, m_big || (m_sum[63:SW] != 0));
      end
    end
  end

  task automatic drive(input bit st, input int unsigned ec, input bit d,
                       input int unsigned rc, input int unsigned ix, input bit ack);
    @(negedge clk);
    bus.startTop      = st;
    bus.expectedCount = ec;
    bus.done          = d;
    bus.resultCount   = rc[5:0];
    bus.extraDataIn   = ix[EW-1:0];
    bus.resultAck     = ack;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic wait_valid(input int budget, output int waited);
    waited = 0;
    do begin
      idle();
      waited++;
    end while (!bus.resultValid && waited < budget);
  endtask

  task automatic check_result(input string tag, input int waited, input logic [63:0] sum,
                              input int unsigned cnt, input int unsigned cs, input bit ovf);
    chk({tag, "_latency"}, waited, 2);
    chk({tag, "_valid"}, bus.resultValid, 1);
    chk({tag, "_sum"}, bus.sumOut, sum);
    chk({tag, "_count"}, bus.countOut, cnt);
    chk({tag, "_checksum"}, bus.checksumOut, cs);
    chk({tag, "_overflow"}, bus.overflow, ovf);
  endtask

  task automatic ack_and_check(input string tag);
    drive(0, 0, 0, 0, 0, 1);
    idle();
    chk({tag, "_valid_after_ack"}, bus.resultValid, 0);
    chk({tag, "_busy_after_ack"}, bus.busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, bus.resultValid, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_sum"}, bus.sumOut, 0);
    chk({tag, "_count"}, bus.countOut, 0);
    chk({tag, "_checksum"}, bus.checksumOut, 0);
    chk({tag, "_overflow"}, bus.overflow, 0);
    chk({tag, "_stray"}, bus.strayError, 0);
  endtask

  int w;
  int gaps [4] = '{0, 2, 3, 1};
  int idxs [4] = '{1, 2, 4, 8};

  initial begin
    bus.startTop = 0; bus.expectedCount = '0; bus.done = 0; bus.resultCount = '0;
    bus.extraDataIn = '0; bus.resultAck = 0;
    m_tops = 0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    idle();

    // 1: three back-to-back results
    drive(1, 3, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 1, 0);
    drive(0, 0, 1, 1, 2, 0);
    drive(0, 0, 1, 5, 4, 0);
    wait_valid(20, w);
    check_result("t1", w, 35, 3, 7, 0);
    ack_and_check("t1");

    // 2: gapped results, result held until a late ack
    drive(1, 4, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      repeat (gaps[i]) idle();
      drive(0, 0, 1, 2, idxs[i], 0);
    end
    wait_valid(20, w);
    check_result("t2", w, 16, 4, 15, 0);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("t2_hold", bus.resultValid, 1);
    end
    drive(0, 0, 0, 0, 0, 1);
    chk("t2_hold_ack_cycle", bus.resultValid, 1);
    idle();
    chk("t2_valid_after_ack", bus.resultValid, 0);
    chk("t2_busy_after_ack", bus.busy, 0);

    // 3: empty top
    drive(1, 0, 0, 0, 0, 0);
    wait_valid(20, w);
    check_result("t3", w, 0, 0, 0, 0);
    ack_and_check("t3");

    // 4: carry out of the accumulator, then an out-of-range exponent
    drive(1, 2, 0, 0, 0, 0);
    drive(0, 0, 1, 47, 3, 0);
    drive(0, 0, 1, 47, 5, 0);
    wait_valid(20, w);
    check_result("t4a", w, 0, 2, 6, 1);
    ack_and_check("t4a");
    drive(1, 2, 0, 0, 0, 0);
    drive(0, 0, 1, 3, 1, 0);
    drive(0, 0, 1, 50, 1, 0);
    wait_valid(20, w);
    check_result("t4b", w, 8, 2, 0, 1);
    ack_and_check("t4b");

    // 5: stray results in IDLE and in RESULT
    drive(0, 0, 1, 5, 9, 0);
    idle();
    chk("t5_stray_idle", bus.strayError, 1);
    chk("t5_idle_count", bus.countOut, 2);
    chk("t5_idle_sum", bus.sumOut, 8);
    idle();
    chk("t5_stray_idle_end", bus.strayError, 0);
    drive(1, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 4, 3, 0);
    wait_valid(20, w);
    check_result("t5", w, 16, 1, 3, 0);
    drive(0, 0, 1, 6, 7, 0);
    idle();
    chk("t5_stray_result", bus.strayError, 1);
    chk("t5_result_sum", bus.sumOut, 16);
    chk("t5_result_count", bus.countOut, 1);
    chk("t5_result_valid", bus.resultValid, 1);
    ack_and_check("t5");

    // 6: asynchronous reset in the middle of a top
    drive(1, 5, 0, 0, 0, 0);
    drive(0, 0, 1, 3, 1, 0);
    drive(0, 0, 1, 4, 2, 0);
    idle();
    chk("t6_busy_before_reset", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("t6_async");
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 3, 0, 0);
    wait_valid(20, w);
    check_result("t6", w, 8, 1, 0, 0);
    ack_and_check("t6");

    // Random traffic: overlapping starts, strays, random acks, wide exponents
    m_tops = 0;
    for (int i = 0; i < 3000; i++) begin
      int unsigned rc;
      int unsigned sel;
      sel = $urandom_range(0, 9);
      if (sel == 0) rc = $urandom_range(48, 63);
      else if (sel < 4) rc = $urandom_range(44, 47);
      else rc = $urandom_range(0, 47);
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 5), $urandom_range(0, 1) == 1,
            rc, $urandom, $urandom_range(0, 3) == 0);
    end
    idle();
    chk("random_tops_completed", m_tops > 20, 1);

    repeat (2) idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
